// File: rtl/shift_issue_stage.sv
// shift_issue_stage: two-deep issue/retire stage around the shift unit with valid/ready on both sides.
// Optional macro SHIFT_ISSUE_ROTR_EN turns ctrl=11 into ROTR; otherwise ctrl=11 passes rt through.
module shift_issue_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_ctrl,
   input  logic              in_var,
   input  logic [4:0]        in_shamt,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [4:0]        in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        out_rd,
   output logic [CNT_W-1:0]  retired
);
   logic              s1_valid;
   logic [1:0]        s1_ctrl;
   logic [4:0]        s1_amt;
   logic [DATA_W-1:0] s1_rt;
   logic [4:0]        s1_rd;
   logic              s2_adv;
   logic              accept;
   logic [DATA_W-1:0] sll_res;
   logic [DATA_W-1:0] srl_res;
   logic signed [DATA_W-1:0] sra_res;
   logic [DATA_W-1:0] alt_res;
   logic [DATA_W-1:0] res;
   logic              unused_rs;

   // only rs[4:0] ever feeds the amount
   assign unused_rs = ^in_rs[DATA_W-1:5];

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign accept   = in_valid && in_ready;

   assign sll_res = s1_rt << s1_amt;
   assign srl_res = s1_rt >> s1_amt;
   assign sra_res = $signed(s1_rt) >>> s1_amt;
`ifdef SHIFT_ISSUE_ROTR_EN
   // amount 0 makes the left term shift by 32, which yields zero, so the result is rt
   assign alt_res = srl_res | (s1_rt << (6'd32 - {1'b0, s1_amt}));
`else
   assign alt_res = s1_rt;
`endif
   assign res = (s1_ctrl == 2'b00) ? sll_res :
                (s1_ctrl == 2'b01) ? srl_res :
                (s1_ctrl == 2'b10) ? sra_res : alt_res;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_ctrl   <= '0;
         s1_amt    <= '0;
         s1_rt     <= '0;
         s1_rd     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_rd    <= '0;
         retired   <= '0;
      end else begin
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= res;
               out_rd   <= s1_rd;
            end
         end
         if (s2_adv || !s1_valid) begin
            s1_valid <= accept;
            if (accept) begin
               s1_ctrl <= in_ctrl;
               s1_amt  <= in_var ? in_rs[4:0] : in_shamt;
               s1_rt   <= in_rt;
               s1_rd   <= in_rd;
            end
         end
         if (out_valid && out_ready && retired != {CNT_W{1'b1}})
            retired <= retired + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed vectors plus stall, reset-flush and counter-saturation sequences.
module tb_shift_issue_stage;
   localparam int CW = 4;
   logic        clk = 0;
   logic        reset = 1;
   logic        in_valid = 0;
   logic        in_ready;
   logic [1:0]  in_ctrl = 0;
   logic        in_var = 0;
   logic [4:0]  in_shamt = 0;
   logic [31:0] in_rs = 0;
   logic [31:0] in_rt = 0;
   logic [4:0]  in_rd = 0;
   logic        out_valid;
   logic        out_ready = 1;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [CW-1:0] retired;
   int total = 0;
   int passed = 0;

   shift_issue_stage #(.DATA_W(32), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_var(in_var), .in_shamt(in_shamt), .in_rs(in_rs),
      .in_rt(in_rt), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctrl;
      logic        vr;
      logic [4:0]  shamt;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic [1:0] c, input logic v, input logic [4:0] sa,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
      in_ctrl = c; in_var = v; in_shamt = sa; in_rs = rs; in_rt = rt; in_rd = rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; in_valid = 0; out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   vec_t vt[11];
   logic [31:0] sexp[4];
   logic [4:0]  srd[4];

   initial begin
      vt[0]  = '{2'b00, 1'b0, 5'd3,  32'h0,          32'd10,         5'd5,  32'd80};
      vt[1]  = '{2'b10, 1'b1, 5'd0,  32'h0000_002A,  32'hFFFF_FFEF,  5'd6,  32'hFFFF_FFFF};
      vt[2]  = '{2'b01, 1'b1, 5'd0,  32'h0000_002A,  32'hFFFF_FFEF,  5'd7,  32'h003F_FFFF};
      vt[3]  = '{2'b00, 1'b1, 5'd9,  32'h0000_0021,  32'h0000_0001,  5'd8,  32'h0000_0002};
      vt[4]  = '{2'b10, 1'b0, 5'd0,  32'h0,          32'h8000_0000,  5'd9,  32'h8000_0000};
      vt[5]  = '{2'b10, 1'b0, 5'd31, 32'h0,          32'h8000_0001,  5'd10, 32'hFFFF_FFFF};
      vt[6]  = '{2'b10, 1'b1, 5'd0,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  5'd11, 32'h0000_0000};
      vt[7]  = '{2'b01, 1'b0, 5'd31, 32'h0,          32'h8000_0000,  5'd12, 32'h0000_0001};
      vt[8]  = '{2'b00, 1'b0, 5'd4,  32'h0000_001F,  32'h0000_0001,  5'd31, 32'h0000_0010};
`ifdef SHIFT_ISSUE_ROTR_EN
      vt[9]  = '{2'b11, 1'b0, 5'd4,  32'h0,          32'h0000_00F1,  5'd13, 32'h1000_000F};
`else
      vt[9]  = '{2'b11, 1'b0, 5'd4,  32'h0,          32'h0000_00F1,  5'd13, 32'h0000_00F1};
`endif
      vt[10] = '{2'b11, 1'b1, 5'd7,  32'h0000_0020,  32'h1234_5678,  5'd14, 32'h1234_5678};

      @(negedge clk);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_retired", 32'(retired), 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_out_rd", 32'(out_rd), 32'd0);

      foreach (vt[i]) begin
         drive(vt[i].ctrl, vt[i].vr, vt[i].shamt, vt[i].rs, vt[i].rt, vt[i].rd);
         in_valid = 1;
         #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
         in_valid = 0;
         chk("vec_latency_not_early", 32'(out_valid), 32'd0);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
         chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(vt[i].rd));
      end
      @(negedge clk);
      chk("vec_retired", 32'(retired), 32'd11);
      chk("vec_drained", 32'(out_valid), 32'd0);

      // back-to-back stream with a 3-cycle writeback stall
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sexp[i] = (32'(i) + 32'd1) << i;
         srd[i]  = 5'(i + 1);
      end
      begin
         int k = 0;
         int got = 0;
         logic prev_stall = 0;
         logic saw_block = 0;
         logic [31:0] prev_data = 0;
         logic [4:0]  prev_rd = 0;
         for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (prev_stall) begin
               chk("stall_data_hold", out_data, prev_data);
               chk("stall_rd_hold", 32'(out_rd), 32'(prev_rd));
            end
            out_ready = !(c >= 2 && c <= 4);
            if (out_valid && out_ready) begin
               chk($sformatf("stream%0d_data", got), out_data, sexp[got]);
               chk($sformatf("stream%0d_rd", got), 32'(out_rd), 32'(srd[got]));
               got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_rd = out_rd;
            if (k < 4) begin
               drive(2'b00, 1'b0, 5'(k), 32'h0, 32'(k + 1), 5'(k + 1));
               in_valid = 1;
            end else in_valid = 0;
            #1;
            if (in_valid && !in_ready) saw_block = 1;
            if (in_valid && in_ready) k++;
         end
         chk("stream_all_results", 32'(got), 32'd4);
         chk("stream_in_ready_dropped", 32'(saw_block), 32'd1);
      end
      @(negedge clk);
      in_valid = 0;
      chk("stream_retired", 32'(retired), 32'd4);

      // reset with two ops in flight
      do_reset();
      @(negedge clk);
      out_ready = 0;
      drive(2'b00, 1'b0, 5'd1, 32'h0, 32'h0000_0003, 5'd1);
      in_valid = 1;
      @(negedge clk);
      drive(2'b00, 1'b0, 5'd2, 32'h0, 32'h0000_0005, 5'd2);
      @(negedge clk);
      in_valid = 0;
      chk("flush_pre_valid", 32'(out_valid), 32'd1);
      reset = 1;
      out_ready = 1;
      @(negedge clk);
      reset = 0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_retired", 32'(retired), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("flush_no_stale", 32'(out_valid), 32'd0);
      chk("flush_retired_idle", 32'(retired), 32'd0);

      // retired saturates instead of wrapping
      do_reset();
      @(negedge clk);
      drive(2'b01, 1'b0, 5'd1, 32'h0, 32'h0000_0010, 5'd3);
      in_valid = 1;
      out_ready = 1;
      repeat (20) @(negedge clk);
      in_valid = 0;
      repeat (3) @(negedge clk);
      chk("sat_retired", 32'(retired), 32'd15);
      chk("sat_drained", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
